alu_bist_ctrl: RTL
==================

// Module: alu_bist_ctrl
// PURPOSE
//  Built-in self-test initiator for the combinational ALU: the driving end of the ALU operand/select interface.
//  - Generates pseudo-random A/B operands from an LFSR and sweeps every ALU select code.
//  - Compresses ALU_Out/CarryOut/ZeroOut into a MISR signature and compares it with a golden value.
//  - Sits beside the ALU in the datapath; the top level muxes ALU inputs to this block while bist_active=1.
// PARAMETERS
//  SEED        32'h0000_0001  LFSR seed; 0 is illegal and is mapped to 32'h1
//  NUM_VECTORS 64             operand pairs applied (1..65535)
//  NUM_OPS     16             select codes swept per pair, sel = 0..NUM_OPS-1 (1..16)
//  GOLDEN_SIG  32'h0000_0000  expected final MISR value
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high
//  start       in   1   level, sampled in IDLE/DONE; begins a run
//  alu_a       out  32  operand A to ALU (registered)
//  alu_b       out  32  operand B to ALU (registered)
//  alu_sel     out  4   ALU select (registered)
//  alu_out     in   32  ALU result
//  alu_carry   in   1   ALU carry-out flag
//  alu_zero    in   1   ALU zero flag
//  bist_active out  1   high in RUN only; top level muxes ALU inputs on it
//  done        out  1   high in DONE
//  pass        out  1   valid while done=1: final MISR == GOLDEN_SIG
// BEHAVIOUR
//  Reset (async, high): state=IDLE, all outputs 0, lfsr=SEED', misr=32'hFFFF_FFFF, sel=0, vec_cnt=0.
//  States:
//   - IDLE -(start)-> RUN
//   - RUN -(last vector absorbed)-> DONE
//   - DONE -(start)-> RUN
//  Entry to RUN: on the edge sampling start, load lfsr=SEED', misr=FFFF_FFFF, sel=0, vec_cnt=0.
//  Operand mapping in RUN: alu_a=lfsr; alu_b={lfsr[15:0],lfsr[31:16]}; alu_sel=sel. Outputs are 0 outside RUN.
//  Each RUN edge:
//   - misr <= step(misr) ^ {alu_out[31:2], alu_out[1]^alu_carry, alu_out[0]^alu_zero}.
//   - ALU is combinational: the response to operands shown this cycle is absorbed at this edge.
//  Step function: step(x) = {x[30:0],1'b0} ^ (x[31] ? POLY : 0), POLY = 32'h0040_0007 (x^32+x^22+x^2+x+1).
//  sel advance: sel increments each RUN edge. At NUM_OPS-1, sel wraps to 0, lfsr <= step(lfsr) and vec_cnt++.
//  Exit from RUN: the edge absorbing vec_cnt=NUM_VECTORS-1, sel=NUM_OPS-1 moves to DONE.
//   - done=1 and pass are registered on that same edge.
//   - RUN lasts exactly NUM_VECTORS*NUM_OPS cycles.
//  done/pass hold until a new start or reset.
//   - start in DONE clears done and pass on the same edge that re-enters RUN.
//  start is ignored while in RUN; runs cannot be restarted or extended.
//  Reset mid-RUN aborts immediately to the reset values. No partial signature is retained.
//  NUM_OPS=1 gives one select code (0) per vector. vec_cnt width is 16 bits.
// CONFIGURATION
//  ALU_BIST_SIG_OUT_EN defined:
//   - Adds port sig (out, 32) = live MISR register.
//   - sig reads FFFF_FFFF in IDLE and holds its final value in DONE.
//  ALU_BIST_SIG_OUT_EN undefined: no sig port; the MISR is internal. All other behaviour is identical.
// STRUCTURE
//  Package alu_bist_pkg holds:
//   - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//   - LFSR_POLY; MISR_INIT=32'hFFFF_FFFF;
//   - function lfsr_step(x).
//  Sub-module bist_lfsr32, instantiated twice:
//   - 32-bit register with load, enable and data-in XOR;
//   - used as the operand LFSR (data-in tied 0) and as the MISR.
// TESTING
//  1. Reset, start=1 for 1 cycle, SEED=1 -> first RUN cycle shows alu_a=32'h1, alu_b=32'h0001_0000, alu_sel=0.
//     Second RUN cycle shows alu_sel=1.
//  2. NUM_VECTORS=4, NUM_OPS=16 -> bist_active high exactly 64 cycles, then done=1.
//     Real ALU attached; bench-model signature equals the MISR; pass=1 when GOLDEN_SIG is set to it.
//  3. Same configuration, bench forces alu_out[0] inverted on vector 2, sel=5 -> done=1, pass=0.
//  4. Assert reset at RUN cycle 20 -> all outputs 0 asynchronously; a fresh start reproduces the signature from test 2.
//  5. start held high through RUN -> still exactly 64 RUN cycles.
//     start still high in DONE -> immediate re-run, done low for 64 cycles.
//  6. SEED=0 -> first alu_a=32'h1.
//     With ALU_BIST_SIG_OUT_EN: sig=FFFF_FFFF in IDLE and sig==final MISR in DONE.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared state encoding, polynomial constants and step function for the ALU BIST
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // x^32 + x^22 + x^2 + x + 1, shared by the operand LFSR and the MISR
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

  // One Galois shift: shift left, fold the outgoing MSB back through the polynomial
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// rtl/bist_lfsr32.sv - 32-bit Galois LFSR/MISR register with load, enable and data-in XOR
module bist_lfsr32
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        en_i,
  input  logic [31:0] din_i,
  output logic [31:0] q_o
);

  logic [31:0] val_q;
  logic [31:0] val_d;

  // Load wins over stepping; with din_i tied to zero this is a plain LFSR
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (en_i) begin
      val_d = lfsr_step(val_q) ^ din_i;
    end
  end

  // State register with asynchronous reset to the configured start value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// rtl/alu_bist_ctrl.sv - ALU BIST initiator: LFSR operands, select sweep, MISR signature; ALU_BIST_SIG_OUT_EN adds the sig port
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int unsigned NUM_VECTORS = 64,
  parameter int unsigned NUM_OPS     = 16,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        bist_active,
  output logic        done,
  output logic        pass
`ifdef ALU_BIST_SIG_OUT_EN
  ,
  output logic [31:0] sig
`endif
);

  // A zero seed would lock the LFSR at zero forever
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [3:0]  LAST_SEL = 4'(NUM_OPS - 1);
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

  bist_state_e state_q;
  logic [3:0]  sel_q;
  logic [3:0]  sel_d;
  logic [15:0] vec_cnt_q;
  logic [15:0] vec_cnt_d;
  logic [31:0] lfsr_q;
  logic [31:0] misr_q;
  logic [31:0] misr_resp;
  logic [31:0] misr_nxt;
  logic [31:0] opnd_nxt;
  logic [31:0] opnd_swp;
  logic        in_run;
  logic        start_run;
  logic        sel_wrap;
  logic        last_edge;
  logic        lfsr_adv;

  // Sequencing decisions and next operand / signature values for this edge
  always_comb begin
    in_run    = (state_q == ST_RUN);
    start_run = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    sel_wrap  = (sel_q == LAST_SEL);
    last_edge = in_run && sel_wrap && (vec_cnt_q == LAST_VEC);
    lfsr_adv  = in_run && sel_wrap;
    // Flags fold into the two LSBs so carry/zero faults also disturb the signature
    misr_resp = {alu_out[31:2], alu_out[1] ^ alu_carry, alu_out[0] ^ alu_zero};
    misr_nxt  = lfsr_step(misr_q) ^ misr_resp;
    opnd_nxt  = start_run ? SEED_EFF : lfsr_step(lfsr_q);
    opnd_swp  = {opnd_nxt[15:0], opnd_nxt[31:16]};
    sel_d     = sel_q;
    vec_cnt_d = vec_cnt_q;
    if (start_run) begin
      sel_d     = 4'd0;
      vec_cnt_d = 16'd0;
    end else if (in_run) begin
      if (sel_wrap) begin
        sel_d     = 4'd0;
        vec_cnt_d = last_edge ? 16'd0 : vec_cnt_q + 16'd1;
      end else begin
        sel_d = sel_q + 4'd1;
      end
    end
  end

  bist_lfsr32 #(
    .RESET_VAL (SEED_EFF)
  ) u_opnd_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_run),
    .load_val_i (SEED_EFF),
    .en_i       (lfsr_adv),
    .din_i      (32'h0),
    .q_o        (lfsr_q)
  );

  bist_lfsr32 #(
    .RESET_VAL (MISR_INIT)
  ) u_misr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_run),
    .load_val_i (MISR_INIT),
    .en_i       (in_run),
    .din_i      (misr_resp),
    .q_o        (misr_q)
  );

  // Control FSM; ALU-facing outputs are registered and forced to zero outside RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= 4'd0;
      vec_cnt_q   <= 16'd0;
      alu_a       <= 32'h0;
      alu_b       <= 32'h0;
      alu_sel     <= 4'd0;
      bist_active <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      vec_cnt_q <= vec_cnt_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_RUN;
            alu_a       <= opnd_nxt;
            alu_b       <= opnd_swp;
            alu_sel     <= 4'd0;
            bist_active <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_edge) begin
            state_q     <= ST_DONE;
            alu_a       <= 32'h0;
            alu_b       <= 32'h0;
            alu_sel     <= 4'd0;
            bist_active <= 1'b0;
            done        <= 1'b1;
            pass        <= (misr_nxt == GOLDEN_SIG);
          end else begin
            alu_sel <= sel_d;
            if (sel_wrap) begin
              alu_a <= opnd_nxt;
              alu_b <= opnd_swp;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_BIST_SIG_OUT_EN
  assign sig = misr_q;
`endif

endmodule
